// File: rtl/serial_fifo_bridge_pkg.sv
// Shared definitions for the serial FIFO bridge.
//   Serial_mode_t       2-bit controller/CPU status word
//   SERIAL_TX_IDLE      bit index: transmitter idle (ser_mode)
//   SERIAL_RX_READY     bit index: received byte ready (ser_mode)
//   Tx_state_t          transmit-side FSM states
//   Rx_state_t          receive-side FSM states
//   bridge_dbg_t        observability bundle (FSM states and FIFO fill levels)
package serial_fifo_bridge_pkg;

    typedef logic [1:0] Serial_mode_t;

    localparam int SERIAL_TX_IDLE     = 0;
    localparam int SERIAL_RX_READY    = 1;
    localparam int FIFO_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_BUSY = 2'd1,
        TX_WAIT_IDLE = 2'd2
    } Tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'd0,
        RX_CAPTURE  = 2'd1,
        RX_WAIT_CLR = 2'd2
    } Rx_state_t;

    // Fill levels are zero-extended to 16 bits so the bundle width does not
    // depend on the FIFO depth.
    typedef struct packed {
        Tx_state_t   tx_state;
        Rx_state_t   rx_state;
        logic [15:0] tx_count;
        logic [15:0] rx_count;
    } bridge_dbg_t;

endpackage

// File: rtl/serial_fifo_bridge_fifo.sv
// byte_fifo: synchronous byte FIFO with first-word fall-through head.
//   clk, rst    clock, synchronous active-high reset (empties the FIFO)
//   push        write push_data when not full (ignored when full)
//   push_data   byte to store
//   pop         drop the head when not empty (ignored when empty)
//   head        current head byte (stale contents when empty)
//   full/empty  count == DEPTH / count == 0
//   count       number of stored bytes, PTR_W+1 bits
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module byte_fifo
    import serial_fifo_bridge_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       head,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_fifo_bridge.sv
// serial_fifo_bridge: CPU-side TX/RX byte buffering in front of a serial controller.
//   clk, rst        clock, synchronous active-high reset
//   cpu_write       push cpu_wdata into the TX FIFO (sticky tx_overflow if full)
//   cpu_read        pop the RX FIFO head (ignored when empty)
//   cpu_rdata       RX FIFO head, 0 when empty
//   cpu_status      [0] TX FIFO not full, [1] RX FIFO not empty
//   tx_overflow     sticky: a CPU write hit a full TX FIFO
//   ser_write_op    one-cycle send request, byte on ser_data_write
//   ser_read_op     one-cycle receive request
//   ser_mode        controller status: [0] transmitter idle, [1] RX byte ready
//   ser_data_read   controller receive buffer
//   dbg             FSM states and FIFO fill levels
//
// Controller handshake: a request is a single-cycle pulse issued only while
// the matching ser_mode bit is 1. After a send request the bridge waits for
// ser_mode[0] to fall (byte latched) and rise again before the next send.
// After a receive request the byte is captured in the following cycle, and
// the bridge waits for ser_mode[1] to fall so the same byte is never read twice.
module serial_fifo_bridge
    import serial_fifo_bridge_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_write,
    input  logic [7:0]   cpu_wdata,
    input  logic         cpu_read,
    output logic [7:0]   cpu_rdata,
    output Serial_mode_t cpu_status,
    output logic         tx_overflow,
    output logic         ser_write_op,
    output logic [7:0]   ser_data_write,
    output logic         ser_read_op,
    input  Serial_mode_t ser_mode,
    input  logic [7:0]   ser_data_read,
    output bridge_dbg_t  dbg
);

    Tx_state_t      tx_state;
    Rx_state_t      rx_state;

    logic           tx_pop;
    logic           tx_full;
    logic           tx_empty;
    logic [7:0]     tx_head;
    logic [PTR_W:0] tx_count;

    logic           rx_push;
    logic           rx_full;
    logic           rx_empty;
    logic [7:0]     rx_head;
    logic [PTR_W:0] rx_count;

    // The head leaves the TX FIFO in the same cycle it is registered onto
    // ser_data_write.
    assign tx_pop  = (tx_state == TX_IDLE) && !tx_empty && ser_mode[SERIAL_TX_IDLE];
    // RX_CAPTURE is only entered when the FIFO had room, and only the CPU
    // can change the count meanwhile (by popping), so this push always lands.
    assign rx_push = (rx_state == RX_CAPTURE);

    byte_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cpu_write),
        .push_data (cpu_wdata),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    byte_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (ser_data_read),
        .pop       (cpu_read),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    assign cpu_rdata  = rx_empty ? 8'h00 : rx_head;
    assign cpu_status = {!rx_empty, !tx_full};
    assign dbg        = {tx_state, rx_state, 16'(tx_count), 16'(rx_count)};

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_overflow <= 1'b0;
        end else if (cpu_write && tx_full) begin
            tx_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state       <= TX_IDLE;
            ser_write_op   <= 1'b0;
            ser_data_write <= 8'h00;
        end else begin
            ser_write_op <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        ser_write_op   <= 1'b1;
                        ser_data_write <= tx_head;
                        tx_state       <= TX_WAIT_BUSY;
                    end
                end
                TX_WAIT_BUSY: begin
                    if (!ser_mode[SERIAL_TX_IDLE]) begin
                        tx_state <= TX_WAIT_IDLE;
                    end
                end
                TX_WAIT_IDLE: begin
                    if (ser_mode[SERIAL_TX_IDLE]) begin
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state    <= RX_IDLE;
            ser_read_op <= 1'b0;
        end else begin
            ser_read_op <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    // Hold off while full; the byte stays in the controller.
                    if (ser_mode[SERIAL_RX_READY] && !rx_full) begin
                        ser_read_op <= 1'b1;
                        rx_state    <= RX_CAPTURE;
                    end
                end
                RX_CAPTURE: begin
                    rx_state <= RX_WAIT_CLR;
                end
                RX_WAIT_CLR: begin
                    if (!ser_mode[SERIAL_RX_READY]) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule
